// File: rtl/img_pkg.sv
// Shared image geometry defaults, packer state encoding and the output event
// record passed between the packer datapath and its output staging.
package img_pkg;

   localparam int WORD_W_DEF  = 16;
   localparam int IMG_W_DEF   = 640;
   localparam int IMG_H_DEF   = 480;
   localparam int PIX_TOT_DEF = IMG_W_DEF * IMG_H_DEF;
   localparam int PIX_CNT_W   = 19;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PACK = 1'b1;

   // A frame close with no word attached has close=1 and vld=0.
   typedef struct packed {
      logic vld;
      logic sop;
      logic eop;
      logic close;
      logic err;
   } evt_t;

endpackage

// File: rtl/edge_bit_packer_frame_len_chk.sv
// Frame length checker: counts pixels of the open frame and, on each issued frame
// close, pulses frm_err for bad-length frames and advances the frame counter.
module frame_len_chk import img_pkg::*; #(
   parameter int PIX_TOT = PIX_TOT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic        i_pix,
   input  logic        i_evt_close,
   input  logic        i_evt_err,
   output logic        o_len_bad,
   output logic        o_frm_err,
   output logic [15:0] o_frm_cnt
);

   localparam logic [PIX_CNT_W-1:0] PIX_MAX   = '1;
   localparam logic [PIX_CNT_W-1:0] PIX_TOT_C = PIX_CNT_W'(PIX_TOT);

   logic [PIX_CNT_W-1:0] r_pix_cnt;
   logic [PIX_CNT_W-1:0] w_pix_next;
   logic                 r_frm_err;
   logic [15:0]          r_frm_cnt;

   // Count including the current pixel, so an eop pixel is judged on the final length.
   always_comb begin
      w_pix_next = r_pix_cnt;
      if (i_start) begin
         w_pix_next = PIX_CNT_W'(1);
      end else if (i_pix && (r_pix_cnt != PIX_MAX)) begin
         w_pix_next = r_pix_cnt + PIX_CNT_W'(1);
      end
   end

   assign o_len_bad = (w_pix_next != PIX_TOT_C);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pix_cnt <= '0;
         r_frm_err <= 1'b0;
         r_frm_cnt <= '0;
      end else begin
         r_pix_cnt <= w_pix_next;
         r_frm_err <= i_evt_close & i_evt_err;
         if (i_evt_close) begin
            r_frm_cnt <= r_frm_cnt + 16'd1;
         end
      end
   end

   assign o_frm_err = r_frm_err;
   assign o_frm_cnt = r_frm_cnt;

endmodule

// File: rtl/edge_bit_packer.sv
// Packs WORD_W consecutive 1-bit edge pixels into MSB-first words, keeping
// sop/eop framing and flushing zero-padded partial words on eop or restart.
module edge_bit_packer import img_pkg::*; #(
   parameter int WORD_W = WORD_W_DEF,
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din,
   input  logic              din_vld,
   input  logic              din_sop,
   input  logic              din_eop,
   output logic [WORD_W-1:0] dout,
   output logic              dout_vld,
   output logic              dout_sop,
   output logic              dout_eop,
   output logic              frm_err,
   output logic [15:0]       frm_cnt
);

   localparam int BCW = $clog2(WORD_W) + 1;
   localparam logic [WORD_W-1:0] MSB_ONE = {1'b1, {(WORD_W-1){1'b0}}};

   logic [0:0]        r_state;
   logic [WORD_W-1:0] r_shift;
   logic [BCW-1:0]    r_bit_cnt;
   logic              r_first;
   evt_t              r_hold;
   logic [WORD_W-1:0] r_hold_word;
   logic [WORD_W-1:0] r_dout;
   logic              r_dout_vld;
   logic              r_dout_sop;
   logic              r_dout_eop;

   logic [0:0]        w_state_n;
   logic [WORD_W-1:0] w_shift_n;
   logic [BCW-1:0]    w_bit_cnt_n;
   logic              w_first_n;
   logic [WORD_W-1:0] w_new_word;
   logic [WORD_W-1:0] w_placed;
   logic [BCW-1:0]    w_cnt_inc;
   evt_t              w_a;
   evt_t              w_b;
   logic [WORD_W-1:0] w_a_word;
   logic [WORD_W-1:0] w_b_word;
   evt_t              w_out;
   logic [WORD_W-1:0] w_out_word;
   evt_t              w_hold_n;
   logic [WORD_W-1:0] w_hold_word_n;
   logic              w_len_bad;

   assign w_new_word = din ? MSB_ONE : '0;
   assign w_placed   = r_shift | (w_new_word >> r_bit_cnt);
   assign w_cnt_inc  = r_bit_cnt + BCW'(1);

   // Event A closes or completes the running frame; event B only exists when a
   // restart pixel also carries eop and forms its own one-pixel frame.
   always_comb begin
      w_state_n   = r_state;
      w_shift_n   = r_shift;
      w_bit_cnt_n = r_bit_cnt;
      w_first_n   = r_first;
      w_a         = '0;
      w_b         = '0;
      w_a_word    = '0;
      w_b_word    = '0;
      if (din_vld && din_sop) begin
         if (r_state == ST_PACK) begin
            w_a.close = 1'b1;
            w_a.err   = 1'b1;
            if ((r_bit_cnt != '0) || r_first) begin
               w_a.vld  = 1'b1;
               w_a.sop  = r_first;
               w_a.eop  = 1'b1;
               w_a_word = r_shift;
            end
         end
         w_state_n   = ST_PACK;
         w_shift_n   = w_new_word;
         w_bit_cnt_n = BCW'(1);
         w_first_n   = 1'b1;
         if (din_eop) begin
            w_b         = '{vld: 1'b1, sop: 1'b1, eop: 1'b1, close: 1'b1, err: w_len_bad};
            w_b_word    = w_new_word;
            w_state_n   = ST_IDLE;
            w_shift_n   = '0;
            w_bit_cnt_n = '0;
            w_first_n   = 1'b0;
         end
      end else if (din_vld && (r_state == ST_PACK)) begin
         if (din_eop) begin
            w_a         = '{vld: 1'b1, sop: r_first, eop: 1'b1, close: 1'b1, err: w_len_bad};
            w_a_word    = w_placed;
            w_state_n   = ST_IDLE;
            w_shift_n   = '0;
            w_bit_cnt_n = '0;
            w_first_n   = 1'b0;
         end else if (w_cnt_inc == BCW'(WORD_W)) begin
            w_a         = '{vld: 1'b1, sop: r_first, eop: 1'b0, close: 1'b0, err: 1'b0};
            w_a_word    = w_placed;
            w_shift_n   = '0;
            w_bit_cnt_n = '0;
            w_first_n   = 1'b0;
         end else begin
            w_shift_n   = w_placed;
            w_bit_cnt_n = w_cnt_inc;
         end
      end
   end

   // One event leaves per cycle, oldest first; a second one waits in the holding slot.
   always_comb begin
      w_out         = w_b;
      w_out_word    = w_b_word;
      w_hold_n      = '0;
      w_hold_word_n = '0;
      if (r_hold.vld || r_hold.close) begin
         w_out      = r_hold;
         w_out_word = r_hold_word;
         if (w_a.vld || w_a.close) begin
            w_hold_n      = w_a;
            w_hold_word_n = w_a_word;
         end else begin
            w_hold_n      = w_b;
            w_hold_word_n = w_b_word;
         end
      end else if (w_a.vld || w_a.close) begin
         w_out         = w_a;
         w_out_word    = w_a_word;
         w_hold_n      = w_b;
         w_hold_word_n = w_b_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_first     <= 1'b0;
         r_hold      <= '0;
         r_hold_word <= '0;
         r_dout      <= '0;
         r_dout_vld  <= 1'b0;
         r_dout_sop  <= 1'b0;
         r_dout_eop  <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_shift     <= w_shift_n;
         r_bit_cnt   <= w_bit_cnt_n;
         r_first     <= w_first_n;
         r_hold      <= w_hold_n;
         r_hold_word <= w_hold_word_n;
         r_dout      <= w_out_word;
         r_dout_vld  <= w_out.vld;
         r_dout_sop  <= w_out.vld & w_out.sop;
         r_dout_eop  <= w_out.vld & w_out.eop;
      end
   end

   frame_len_chk #(
      .PIX_TOT (IMG_W * IMG_H)
   ) u_len_chk (
      .clk         (clk),
      .rst         (rst),
      .i_start     (din_vld & din_sop),
      .i_pix       (din_vld & ~din_sop & (r_state == ST_PACK)),
      .i_evt_close (w_out.close),
      .i_evt_err   (w_out.err),
      .o_len_bad   (w_len_bad),
      .o_frm_err   (frm_err),
      .o_frm_cnt   (frm_cnt)
   );

   assign dout     = r_dout;
   assign dout_vld = r_dout_vld;
   assign dout_sop = r_dout_sop;
   assign dout_eop = r_dout_eop;

endmodule

// File: tb/tb_edge_bit_packer.sv
// Testbench for edge_bit_packer on a 16x2 image: a frame-level reference model
// checked every cycle, directed scenarios with literal word expectations, then random traffic.
module tb_edge_bit_packer;

   localparam int WW = 16;
   localparam int IW = 16;
   localparam int IH = 2;
   localparam int PT = IW * IH;

   logic        clk = 1'b0;
   logic        rst;
   logic        din;
   logic        din_vld;
   logic        din_sop;
   logic        din_eop;
   logic [15:0] dout;
   logic        dout_vld;
   logic        dout_sop;
   logic        dout_eop;
   logic        frm_err;
   logic [15:0] frm_cnt;

   always #5 clk = ~clk;

   edge_bit_packer #(
      .WORD_W (WW),
      .IMG_W  (IW),
      .IMG_H  (IH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .din_vld  (din_vld),
      .din_sop  (din_sop),
      .din_eop  (din_eop),
      .dout     (dout),
      .dout_vld (dout_vld),
      .dout_sop (dout_sop),
      .dout_eop (dout_eop),
      .frm_err  (frm_err),
      .frm_cnt  (frm_cnt)
   );

   typedef struct {
      logic [15:0] word;
      bit vld, sop, eop, close, err;
   } mevt_t;

   typedef struct {
      logic [15:0] word;
      bit vld, sop, eop, err, rstChk;
      logic [15:0] cnt;
   } exp_t;

   typedef struct {
      logic [15:0] word;
      bit sop, eop, err;
      logic [15:0] cnt;
   } log_t;

   int    nVec = 0;
   int    nFail = 0;
   bit    armed = 0;
   mevt_t pend[$];
   bit    mPix[$];
   bit    mActive;
   int    mLen;
   bit    mEmitted;
   logic [15:0] expCnt;
   exp_t  expNext;
   exp_t  curExp;
   log_t  logQ[$];

   // Frame-level model: pixels of the open frame are kept as a list; every
   // completed word or frame close becomes an event, and one event leaves per cycle.
   function automatic logic [15:0] packWord();
      logic [15:0] w = '0;
      for (int i = 0; i < mPix.size(); i++) begin
         if (mPix[i]) w = w | (16'h8000 >> i);
      end
      return w;
   endfunction

   function automatic void pushEvt(bit vld, bit sop, bit eop, bit close, bit err);
      mevt_t ev;
      ev.word  = vld ? packWord() : 16'h0000;
      ev.vld   = vld;
      ev.sop   = sop;
      ev.eop   = eop;
      ev.close = close;
      ev.err   = err;
      pend.push_back(ev);
   endfunction

   function automatic void modelStep(bit r, bit v, bit s, bit e, bit d);
      mevt_t ev;
      if (r) begin
         pend.delete();
         mPix.delete();
         mActive  = 0;
         mLen     = 0;
         mEmitted = 0;
         expCnt   = 16'd0;
         expNext  = '{word: 16'h0000, vld: 0, sop: 0, eop: 0, err: 0, rstChk: 1, cnt: 16'd0};
         return;
      end
      if (v) begin
         if (s) begin
            if (mActive) begin
               if (mPix.size() > 0 || !mEmitted) pushEvt(1, !mEmitted, 1, 1, 1);
               else pushEvt(0, 0, 0, 1, 1);
            end
            mActive = 1;
            mPix.delete();
            mPix.push_back(d);
            mLen     = 1;
            mEmitted = 0;
         end else if (mActive) begin
            mPix.push_back(d);
            mLen++;
         end
         if (mActive) begin
            if (e) begin
               pushEvt(1, !mEmitted, 1, 1, mLen != PT);
               mActive = 0;
               mPix.delete();
            end else if (mPix.size() == WW) begin
               pushEvt(1, !mEmitted, 0, 0, 0);
               mEmitted = 1;
               mPix.delete();
            end
         end
      end
      if (pend.size() > 0) begin
         ev = pend.pop_front();
         if (ev.close) expCnt = expCnt + 16'd1;
         expNext = '{word: ev.word, vld: ev.vld, sop: ev.vld && ev.sop, eop: ev.vld && ev.eop,
                     err: ev.close && ev.err, rstChk: 0, cnt: expCnt};
      end else begin
         expNext = '{word: 16'h0000, vld: 0, sop: 0, eop: 0, err: 0, rstChk: 0, cnt: expCnt};
      end
   endfunction

   // Drives one cycle of inputs from the falling edge and advances the model.
   task automatic applyStimulus(input bit r, input bit v, input bit s, input bit e, input bit d);
      rst     = r;
      din_vld = v;
      din_sop = s;
      din_eop = e;
      din     = d;
      modelStep(r, v, s, e, d);
      armed = 1;
      @(negedge clk);
   endtask

   task automatic checkOutput(input exp_t c);
      bit bad;
      nVec++;
      bad = (dout_vld !== c.vld) || (dout_sop !== c.sop) || (dout_eop !== c.eop) ||
            (frm_err !== c.err) || (frm_cnt !== c.cnt) ||
            ((c.vld || c.rstChk) && (dout !== c.word));
      if (bad) begin
         nFail++;
         $display("[TB] FAIL cycle-check t=%0t: got dout=%h vld=%b sop=%b eop=%b err=%b cnt=%0d, required dout=%h vld=%b sop=%b eop=%b err=%b cnt=%0d",
                  $time, dout, dout_vld, dout_sop, dout_eop, frm_err, frm_cnt,
                  c.word, c.vld, c.sop, c.eop, c.err, c.cnt);
      end
      if (dout_vld === 1'b1 || frm_err === 1'b1) begin
         logQ.push_back('{word: dout, sop: dout_sop, eop: dout_eop, err: frm_err, cnt: frm_cnt});
      end
   endtask

   always @(posedge clk) begin
      if (armed) begin
         curExp = expNext;
         #1;
         checkOutput(curExp);
      end
   end

   task automatic checkLogSize(input string name, input int n);
      nVec++;
      if (logQ.size() != n) begin
         nFail++;
         $display("[TB] FAIL %s: got %0d output events, required %0d", name, logQ.size(), n);
      end
   endtask

   task automatic checkLog(input string name, input int idx, input logic [15:0] w,
                           input bit s, input bit e, input bit err, input logic [15:0] cnt);
      nVec++;
      if (idx >= logQ.size()) begin
         nFail++;
         $display("[TB] FAIL %s: event %0d missing, required word=%h", name, idx, w);
      end else if (logQ[idx].word !== w || logQ[idx].sop !== s || logQ[idx].eop !== e ||
                   logQ[idx].err !== err || logQ[idx].cnt !== cnt) begin
         nFail++;
         $display("[TB] FAIL %s: got word=%h sop=%b eop=%b err=%b cnt=%0d, required word=%h sop=%b eop=%b err=%b cnt=%0d",
                  name, logQ[idx].word, logQ[idx].sop, logQ[idx].eop, logQ[idx].err, logQ[idx].cnt,
                  w, s, e, err, cnt);
      end
   endtask

   task automatic resetDut();
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      logQ.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(0, 0, 0, 0, 0);
   endtask

   task automatic sendFrame(input int n, input bit allOnes, input int gap, input bit withEop);
      bit d;
      for (int i = 0; i < n; i++) begin
         d = allOnes ? 1'b1 : (i % 2 == 0);
         applyStimulus(0, 1, i == 0, withEop && (i == n - 1), d);
         idle(gap);
      end
   endtask

   function automatic int pickLen();
      if ($urandom_range(0, 2) != 0) return PT;
      return int'($urandom_range(1, 48));
   endfunction

   initial begin
      int pos = -1;
      int target = PT;
      rst = 1; din = 0; din_vld = 0; din_sop = 0; din_eop = 0;

      resetDut();
      sendFrame(32, 0, 0, 1);
      idle(3);
      checkLogSize("nominal size", 2);
      checkLog("nominal w0", 0, 16'hAAAA, 1, 0, 0, 16'd0);
      checkLog("nominal w1", 1, 16'hAAAA, 0, 1, 0, 16'd1);

      resetDut();
      sendFrame(20, 1, 0, 1);
      idle(3);
      checkLogSize("short size", 2);
      checkLog("short w0", 0, 16'hFFFF, 1, 0, 0, 16'd0);
      checkLog("short w1", 1, 16'hF000, 0, 1, 1, 16'd1);

      resetDut();
      sendFrame(32, 0, 2, 1);
      idle(3);
      checkLogSize("gapped size", 2);
      checkLog("gapped w0", 0, 16'hAAAA, 1, 0, 0, 16'd0);
      checkLog("gapped w1", 1, 16'hAAAA, 0, 1, 0, 16'd1);

      resetDut();
      sendFrame(5, 1, 0, 0);
      sendFrame(32, 0, 0, 1);
      idle(3);
      checkLogSize("restart size", 3);
      checkLog("restart flush", 0, 16'hF800, 1, 1, 1, 16'd1);
      checkLog("restart w0", 1, 16'hAAAA, 1, 0, 0, 16'd1);
      checkLog("restart w1", 2, 16'hAAAA, 0, 1, 0, 16'd2);

      resetDut();
      sendFrame(1, 1, 0, 1);
      idle(3);
      checkLogSize("single size", 1);
      checkLog("single w0", 0, 16'h8000, 1, 1, 1, 16'd1);

      resetDut();
      sendFrame(3, 1, 0, 0);
      applyStimulus(0, 1, 1, 1, 1);
      idle(3);
      checkLogSize("restart+eop size", 2);
      checkLog("restart+eop old", 0, 16'hE000, 1, 1, 1, 16'd1);
      checkLog("restart+eop new", 1, 16'h8000, 1, 1, 1, 16'd2);

      resetDut();
      sendFrame(7, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, i == 4, 1);
      idle(3);
      checkLogSize("reset-mid quiet", 0);
      applyStimulus(0, 1, 1, 1, 0);
      idle(3);
      checkLogSize("reset-mid size", 1);
      checkLog("reset-mid w0", 0, 16'h0000, 1, 1, 1, 16'd1);

      resetDut();
      for (int k = 0; k < 3000; k++) begin
         bit v, s, e, d;
         if ($urandom_range(0, 499) == 0) begin
            applyStimulus(1, 0, 0, 0, 0);
            pos = -1;
         end else begin
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 1) != 0);
            s = 0;
            e = 0;
            if (!v) begin
               s = ($urandom_range(0, 1) != 0);
               e = ($urandom_range(0, 1) != 0);
            end else begin
               if (pos < 0) begin
                  if ($urandom_range(0, 3) == 0) begin
                     s = 1; pos = 0; target = pickLen();
                  end else begin
                     e = ($urandom_range(0, 7) == 0);
                  end
               end else if ($urandom_range(0, 59) == 0) begin
                  s = 1; pos = 0; target = pickLen();
               end
               if (pos >= 0) begin
                  if (pos >= target - 1 || (s && $urandom_range(0, 9) == 0)) e = 1;
                  pos = e ? -1 : pos + 1;
               end
            end
            applyStimulus(0, v, s, e, d);
         end
      end
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule

// File: doc/edge_bit_packer.md
Name: edge_bit_packer

Overview:
- Sits directly downstream of the Sobel stage. Consumes its 1-bit edge stream (dout/dout_vld/dout_sop/dout_eop), which arrives on this block's din/din_vld/din_sop/din_eop.
- Packs WORD_W consecutive edge pixels into one word for the frame-buffer write path.
- Preserves sop/eop framing, zero-pads and flushes a partial last word, checks frame length and counts completed frames.

Parameters:
- WORD_W, 16: pixels per output word.
- IMG_W, 640: pixels per line.
- IMG_H, 480: lines per frame. Expected pixels per frame PIX_TOT = IMG_W*IMG_H = 307200.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- din  input  1  edge pixel, 1 = edge.
- din_vld  input  1  din valid, one pixel per asserted cycle.
- din_sop  input  1  first pixel of frame; qualified by din_vld.
- din_eop  input  1  last pixel of frame; qualified by din_vld.
- dout  output  WORD_W  packed word; first pixel of the word in the MSB.
- dout_vld  output  1  one-cycle strobe per word.
- dout_sop  output  1  first word of frame; coincident with dout_vld.
- dout_eop  output  1  last word of frame; coincident with dout_vld.
- frm_err  output  1  one-cycle pulse when a frame is closed with pixel count != PIX_TOT.
- frm_cnt  output  16  count of frames closed (eop or abort), wraps at 65535 -> 0.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk, and has priority over all inputs. Reset mid-frame drops the partial word and pixel count, and no flush is emitted.
- Reset values: dout=0, dout_vld=0, dout_sop=0, dout_eop=0, frm_err=0, frm_cnt=0. Internally: state=IDLE, shift register=0, bit_cnt=0, pix_cnt=0, first_word=0.
- All outputs are registered. dout_vld rises 1 cycle after the din_vld cycle that completes a word or carries eop. There is no backpressure.
- din_sop and din_eop are ignored when din_vld=0.
- State IDLE:
  - din_vld without din_sop: pixel discarded, no output.
  - din_vld&din_sop: load pixel into bit WORD_W-1, bit_cnt=1, pix_cnt=1, first_word=1, go to PACK.
- State PACK, each din_vld: place pixel at bit WORD_W-1-bit_cnt, bit_cnt++, pix_cnt++.
  - When bit_cnt reaches WORD_W: emit the word next cycle with dout_sop=first_word, then clear first_word and set bit_cnt=0.
- eop (din_vld&din_eop), in either state including the sop cycle:
  - Emit the current word, with unfilled LSBs forced to 0, and dout_eop=1. dout_sop is also 1 if it is the frame's first word.
  - frm_cnt++. frm_err=1 if the final pix_cnt (including the eop pixel) != PIX_TOT.
  - Go to IDLE.
- sop while in PACK (abort/restart), with din_vld&din_sop:
  - If bit_cnt>0 or first_word, flush the pending partial word with dout_eop=1 and frm_err=1, and frm_cnt++.
  - If bit_cnt==0 and the frame already emitted words, no word is emitted, but frm_err=1 and frm_cnt++ still apply.
  - In the same cycle the new pixel starts a new frame (bit_cnt=1, pix_cnt=1, first_word=1, stay in PACK).
  - If the same cycle also carries eop: the old frame closes as above. The new frame is a 1-pixel frame, emitted on the following cycle as sop+eop with frm_err=1, using a one-word holding register.
- Over-long frame: pix_cnt saturates at 2^19-1, packing continues, and frm_err fires at eop.
- pix_cnt is 19 bits and bit_cnt is clog2(WORD_W)+1 bits.
- Nominal frame: exactly PIX_TOT/WORD_W = 19200 words, the first with dout_sop and the last with dout_eop, with no padding.

Decomposition:
- Shared package img_pkg: IMG_W, IMG_H, PIX_TOT, WORD_W defaults, and the state encoding (IDLE=0, PACK=1).
- One natural sub-module, frame_len_chk. It holds pix_cnt, saturation, frm_err generation and frm_cnt. The packer datapath stays in edge_bit_packer.

Test Plan:
- Nominal frame with IMG_W=16, IMG_H=2 (PIX_TOT=32), alternating 1/0 pixels, sop on pixel 0, eop on pixel 31. Required: 2 words of 16'hAAAA; sop on word 1, eop on word 2; frm_err=0; frm_cnt=1.
- Short frame: 20 pixels all 1, eop on pixel 19. Required: 16'hFFFF (sop), then 16'hF000 (eop) with frm_err=1 on the same cycle.
- Gapped din_vld (1 valid every 3 cycles) over the nominal frame. Required: output identical to the first scenario, each dout_vld exactly 1 cycle after its completing pixel.
- Restart: sop again after 5 pixels of 1. Required: flush 16'hF800 with eop and frm_err=1 and frm_cnt++. The new frame then packs from bit 15.
- Single-pixel frame (din=1, sop&eop in one cycle). Required: 16'h8000 with sop=eop=1 and frm_err=1.
- Reset asserted mid-frame after 7 pixels. Required: all outputs 0 the next cycle, no flush word; pixels without sop are then ignored until the next sop.
